// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes (MIPS funct), FSM states, flag bit indices.
package alu_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned NumFlags = 5;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;

  localparam int unsigned FlagZero  = 0;
  localparam int unsigned FlagNeg   = 1;
  localparam int unsigned FlagCarry = 2;
  localparam int unsigned FlagOvf   = 3;
  localparam int unsigned FlagErr   = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational W-bit ALU: a, b, op -> result and {err, ovf, carry, neg, zero}.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  input  logic [OP_W-1:0]     op,
  output logic [W-1:0]        result,
  output logic [NumFlags-1:0] flags
);

  logic [W:0] sum;
  logic [W:0] diff;
  logic       carry;
  logic       ovf;
  logic       err;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Top bit of the extended difference is the borrow (a < b unsigned).
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    err    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[W-1:0];
        carry  = sum[W];
        ovf    = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        result = diff[W-1:0];
        carry  = diff[W];
        ovf    = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOR: result = ~(a | b);
      // Full b is the shift amount; oversized shifts saturate to 0 / sign fill.
      OP_SRL: result = a >> b;
      OP_SRA: result = $signed(a) >>> b;
      default: err = 1'b1;
    endcase

    flags            = '0;
    flags[FlagZero]  = (result == '0);
    flags[FlagNeg]   = result[W-1];
    flags[FlagCarry] = carry;
    flags[FlagOvf]   = ovf;
    flags[FlagErr]   = err;
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: operands/opcode loaded from a shared bus, start launches one operation,
// result and flags held behind a valid/ready handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        data_in,
  input  logic                ld_a,
  input  logic                ld_b,
  input  logic                ld_op,
  input  logic                start,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        result,
  output logic [NumFlags-1:0] flags
);

  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [OP_W-1:0]     op_q;
  state_e              state_q;
  logic [W-1:0]        core_result;
  logic [NumFlags-1:0] core_flags;

  alu_core #(
    .W(W)
  ) u_core (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .result(core_result),
    .flags (core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // Loads land at the same edge as start, so EXEC sees the new values.
          if (ld_a)  a_q  <= data_in;
          if (ld_b)  b_q  <= data_in;
          if (ld_op) op_q <= OP_W'(data_in);
          if (start) begin
            state_q <= StExec;
            busy    <= 1'b1;
          end
        end
        StExec: begin
          result    <= core_result;
          flags     <= core_flags;
          out_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q   <= StIdle;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: W=8 and W=16 instances driven in lockstep from one bus, checked against
// a plain-arithmetic reference model and directed expectations.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic        ld_a, ld_b, ld_op, start, out_ready;

  logic        busy8, valid8, busy16, valid16;
  logic [7:0]  result8;
  logic [15:0] result16;
  logic [4:0]  flags8, flags16;

  int checks = 0;
  int errors = 0;

  alu_seq #(.W(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in[7:0]),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .ld_op    (ld_op),
    .start    (start),
    .busy     (busy8),
    .out_valid(valid8),
    .out_ready(out_ready),
    .result   (result8),
    .flags    (flags8)
  );

  alu_seq #(.W(16)) dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .ld_op    (ld_op),
    .start    (start),
    .busy     (busy16),
    .out_valid(valid16),
    .out_ready(out_ready),
    .result   (result16),
    .flags    (flags16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed/unsigned integer arithmetic on w-bit values.
  // Returns {err, ovf, carry, neg, zero, result[15:0]}.
  function automatic logic [20:0] model(input int w, input logic [15:0] a_in, b_in,
                                        input logic [5:0] op);
    longint full, half, ua, ub, sa, sb, s, r;
    bit e, v, c;
    full = longint'(1) << w;
    half = full / 2;
    ua = longint'(a_in) % full;
    ub = longint'(b_in) % full;
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    e = 0; v = 0; c = 0; r = 0;
    case (op)
      6'b100000: begin
        r = (ua + ub) % full; c = (ua + ub) >= full;
        s = sa + sb; v = (s >= half) || (s < -half);
      end
      6'b100010: begin
        r = (ua - ub + full) % full; c = ua < ub;
        s = sa - sb; v = (s >= half) || (s < -half);
      end
      6'b100100: r = ua & ub;
      6'b100101: r = ua | ub;
      6'b100110: r = ua ^ ub;
      6'b100111: r = (full - 1) - (ua | ub);
      6'b000010: r = (ub >= w) ? 0 : ua / (longint'(1) << ub);
      6'b000011: r = (sa >>> ((ub >= w) ? w - 1 : ub)) & (full - 1);
      default: begin e = 1; r = 0; end
    endcase
    return {e, v, c, (r >= half), (r == 0), 16'(r)};
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic load(input bit la, lb, lo, input logic [15:0] v);
    data_in = v; ld_a = la; ld_b = lb; ld_op = lo;
    @(negedge clk);
    ld_a = 0; ld_b = 0; ld_op = 0;
  endtask

  task automatic pulse_start(input bit la, input logic [15:0] v);
    data_in = v; ld_a = la; start = 1;
    @(negedge clk);
    start = 0; ld_a = 0;
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 8; i++) begin
      if (valid8 && valid16) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_valid: out_valid8=%b out_valid16=%b, required 1 within 8 cycles",
               valid8, valid16);
    end
  endtask

  task automatic accept();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic do_op(input logic [15:0] a, b, input logic [5:0] op);
    load(1, 0, 0, a);
    load(0, 1, 0, b);
    load(0, 0, 1, {10'd0, op});
    pulse_start(0, 0);
    wait_valid();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy8, valid8, result8, flags8} !== '0) begin
      errors++;
      $display("FAIL reset8: busy=%b valid=%b result=%h flags=%b, required all 0",
               busy8, valid8, result8, flags8);
    end
    checks++;
    if ({busy16, valid16, result16, flags16} !== '0) begin
      errors++;
      $display("FAIL reset16: busy=%b valid=%b result=%h flags=%b, required all 0",
               busy16, valid16, result16, flags16);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_latency_hold();
    bit stable = 1;
    load(1, 0, 0, 16'h000F);
    load(0, 1, 0, 16'h0001);
    load(0, 0, 1, 16'h0020);
    pulse_start(0, 0);
    checks++;
    if (busy8 !== 1 || valid8 !== 0) begin
      errors++;
      $display("FAIL exec_state: busy=%b valid=%b, required busy=1 valid=0", busy8, valid8);
    end
    @(negedge clk);
    checks++;
    if (valid8 !== 1 || valid16 !== 1) begin
      errors++;
      $display("FAIL latency: valid8=%b valid16=%b two cycles after start, required 1",
               valid8, valid16);
    end
    checks++;
    if (result8 !== 8'h10 || flags8 !== 5'b00000) begin
      errors++;
      $display("FAIL add_0f_01: result=%h flags=%b, required 10/00000", result8, flags8);
    end
    checks++;
    if (result16 !== 16'h0010 || flags16 !== 5'b00000) begin
      errors++;
      $display("FAIL add16_0f_01: result=%h flags=%b, required 0010/00000", result16, flags16);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (valid8 !== 1 || busy8 !== 1 || result8 !== 8'h10 || flags8 !== 5'b0) stable = 0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL hold: valid=%b busy=%b result=%h while out_ready=0, required 1/1/10",
               valid8, busy8, result8);
    end
    accept();
    checks++;
    if (valid8 !== 0 || busy8 !== 0 || result8 !== 8'h10) begin
      errors++;
      $display("FAIL handshake: valid=%b busy=%b result=%h, required 0/0/10",
               valid8, busy8, result8);
    end
  endtask

  task automatic test_directed();
    logic [15:0] da   [9] = '{16'h007F, 16'h7FFF, 16'hFFFF, 16'h0003, 16'h0080,
                              16'h8000, 16'h0080, 16'h0000, 16'h000F};
    logic [15:0] db   [9] = '{16'h0001, 16'h0001, 16'h0001, 16'h0005, 16'd9,
                              16'd17,   16'd9,    16'h0000, 16'h00F0};
    logic [5:0]  dop  [9] = '{6'h20, 6'h20, 6'h20, 6'h22, 6'h03, 6'h03, 6'h02, 6'h3F, 6'h27};
    logic [12:0] e8   [9] = '{{5'b01010, 8'h80}, {5'b00101, 8'h00}, {5'b00101, 8'h00},
                              {5'b00110, 8'hFE}, {5'b00010, 8'hFF}, {5'b00001, 8'h00},
                              {5'b00001, 8'h00}, {5'b10001, 8'h00}, {5'b00001, 8'h00}};
    logic [20:0] e16  [9] = '{{5'b00000, 16'h0080}, {5'b01010, 16'h8000},
                              {5'b00101, 16'h0000}, {5'b00110, 16'hFFFE},
                              {5'b00001, 16'h0000}, {5'b00010, 16'hFFFF},
                              {5'b00001, 16'h0000}, {5'b10001, 16'h0000},
                              {5'b00010, 16'hFF00}};
    for (int i = 0; i < 9; i++) begin
      do_op(da[i], db[i], dop[i]);
      checks++;
      if ({flags8, result8} !== e8[i]) begin
        errors++;
        $display("FAIL directed8[%0d]: flags=%b result=%h, required flags=%b result=%h",
                 i, flags8, result8, e8[i][12:8], e8[i][7:0]);
      end
      checks++;
      if ({flags16, result16} !== e16[i]) begin
        errors++;
        $display("FAIL directed16[%0d]: flags=%b result=%h, required flags=%b result=%h",
                 i, flags16, result16, e16[i][20:16], e16[i][15:0]);
      end
      accept();
    end
  endtask

  task automatic test_load_while_busy();
    bit quiet = 1;
    load(0, 1, 0, 16'h0000);
    load(0, 0, 1, 16'h0025);
    pulse_start(1, 16'h0055);
    data_in = 16'h00AA; ld_a = 1; start = 1;
    @(negedge clk);
    @(negedge clk);
    ld_a = 0; start = 0;
    checks++;
    if (valid8 !== 1 || result8 !== 8'h55 || result16 !== 16'h0055) begin
      errors++;
      $display("FAIL load_with_start: valid=%b result8=%h result16=%h, required 1/55/0055",
               valid8, result8, result16);
    end
    accept();
    for (int i = 0; i < 4; i++) begin
      if (valid8 !== 0 || busy8 !== 0) quiet = 0;
      @(negedge clk);
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL start_ignored: valid=%b busy=%b after handshake, required 0/0",
               valid8, busy8);
    end
    pulse_start(0, 0);
    wait_valid();
    checks++;
    if (result8 !== 8'h55 || result16 !== 16'h0055) begin
      errors++;
      $display("FAIL load_ignored: result8=%h result16=%h, required 55/0055", result8, result16);
    end
    accept();
  endtask

  task automatic test_async_reset();
    logic [20:0] exp;
    load(1, 0, 0, 16'h1234);
    pulse_start(0, 0);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({busy8, valid8, result8, flags8} !== '0) begin
      errors++;
      $display("FAIL async_reset8: busy=%b valid=%b result=%h flags=%b, required all 0",
               busy8, valid8, result8, flags8);
    end
    checks++;
    if ({busy16, valid16, result16, flags16} !== '0) begin
      errors++;
      $display("FAIL async_reset16: busy=%b valid=%b result=%h flags=%b, required all 0",
               busy16, valid16, result16, flags16);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    // Registers cleared to 0, so opcode 000000 must report illegal.
    pulse_start(0, 0);
    wait_valid();
    checks++;
    if ({flags8, result8} !== {5'b10001, 8'h00}) begin
      errors++;
      $display("FAIL regs_cleared: flags=%b result=%h, required 10001/00", flags8, result8);
    end
    accept();
    do_op(16'h1234, 16'h0F0F, 6'h20);
    exp = model(16, 16'h1234, 16'h0F0F, 6'h20);
    checks++;
    if ({flags16, result16} !== exp) begin
      errors++;
      $display("FAIL add_after_reset: flags=%b result=%h, required %b/%h",
               flags16, result16, exp[20:16], exp[15:0]);
    end
    accept();
  endtask

  task automatic test_random();
    logic [5:0]  legal [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};
    logic [15:0] a, b;
    logic [5:0]  op;
    logic [20:0] e8, e16;
    bit          held;
    for (int n = 0; n < 300; n++) begin
      a  = 16'($urandom);
      b  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      op = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 7)] : 6'($urandom);
      e8  = model(8, a, b, op);
      e16 = model(16, a, b, op);
      do_op(a, b, op);
      held = 1;
      for (int d = $urandom_range(0, 3); d > 0; d--) begin
        @(negedge clk);
        if (valid8 !== 1 || valid16 !== 1) held = 0;
      end
      checks++;
      if ({flags8, result8} !== {e8[20:16], e8[7:0]} || !held) begin
        errors++;
        $display("FAIL rand8 a=%h b=%h op=%h: flags=%b result=%h held=%b, required %b/%h",
                 a[7:0], b[7:0], op, flags8, result8, held, e8[20:16], e8[7:0]);
      end
      checks++;
      if ({flags16, result16} !== e16) begin
        errors++;
        $display("FAIL rand16 a=%h b=%h op=%h: flags=%b result=%h, required %b/%h",
                 a, b, op, flags16, result16, e16[20:16], e16[15:0]);
      end
      accept();
    end
  endtask

  initial begin
    rst_n = 0;
    data_in = '0;
    ld_a = 0; ld_b = 0; ld_op = 0; start = 0; out_ready = 0;
    test_reset();
    test_latency_hold();
    test_directed();
    test_load_while_busy();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
